// File: rtl/fetch_buffer.sv
// Prefetch buffer ahead of IF/ID: issues instruction-memory reads, queues returned words
// with their PC in a small FIFO, and hands them to decode through a valid/ready handshake.
module fetch_buffer #(
   parameter int          DEPTH    = 4,
   parameter logic [11:0] RESET_PC = 12'h000
) (
   input  logic        CLK,
   input  logic        RSTn,
   output logic        I_MEM_CSN,
   output logic [11:0] I_MEM_ADDR,
   input  logic [31:0] I_MEM_DI,
   input  logic        redirect_valid,
   input  logic [11:0] redirect_pc,
   input  logic        halt_req,
   input  logic        inst_ready,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [11:0] inst_pc,
   output logic [31:0] fetch_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HALTED
   } state_t;

   state_t             state_q, state_d;
   logic [11:0]        fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [31:0]        fetch_count_q, fetch_count_d;
   logic [43:0]        fifo_q [DEPTH];
   logic [43:0]        fifo_d [DEPTH];

   logic        empty;
   logic        full;
   logic        push;
   logic        pop;
   logic [43:0] head;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));
   assign head  = fifo_q[rd_ptr_q];

   // A redirect kills the head in the same cycle so decode never latches a wrong-path word.
   assign inst_valid = !empty && !redirect_valid;
   assign pop        = inst_valid && inst_ready;
   assign push       = (state_q == S_RUN) && !redirect_valid && !halt_req && (!full || pop);

   assign inst        = empty ? NOP : head[31:0];
   assign inst_pc     = empty ? 12'h000 : head[43:32];
   assign I_MEM_ADDR  = fetch_pc_q & 12'hFFC;
   assign I_MEM_CSN   = !((state_q == S_RUN) && !halt_req);
   assign fetch_count = fetch_count_q;

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      fetch_count_d = fetch_count_q;
      fifo_d        = fifo_q;

      if (redirect_valid) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         fetch_pc_d = redirect_pc & 12'hFFC;
         state_d    = S_RUN;
      end else begin
         case (state_q)
            S_IDLE:   state_d = S_RUN;
            S_RUN:    if (halt_req) state_d = S_HALTED;
            default:  state_d = state_q;
         endcase

         if (push) begin
            fifo_d[wr_ptr_q] = {fetch_pc_q, I_MEM_DI};
            wr_ptr_d         = wr_ptr_q + 1'b1;
            fetch_pc_d       = fetch_pc_q + 12'd4;
            fetch_count_d    = fetch_count_q + 32'd1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q       <= S_IDLE;
         fetch_pc_q    <= RESET_PC & 12'hFFC;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         fetch_count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         fetch_count_q <= fetch_count_d;
         fifo_q        <= fifo_d;
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: a queue-based reference model checked every cycle,
// plus hand-computed expectations for reset, back-pressure, redirect, wrap and halt.
module tb_fetch_buffer;

   localparam int          DEPTH    = 4;
   localparam logic [11:0] RESET_PC = 12'h000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b0;
   logic        I_MEM_CSN;
   logic [11:0] I_MEM_ADDR;
   logic [31:0] I_MEM_DI;
   logic        redirect_valid = 1'b0;
   logic [11:0] redirect_pc = 12'h000;
   logic        halt_req = 1'b0;
   logic        inst_ready = 1'b0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [11:0] inst_pc;
   logic [31:0] fetch_count;

   int assertCount = 0;
   int failCount   = 0;

   fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .CLK(CLK), .RSTn(RSTn),
      .I_MEM_CSN(I_MEM_CSN), .I_MEM_ADDR(I_MEM_ADDR), .I_MEM_DI(I_MEM_DI),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt_req(halt_req), .inst_ready(inst_ready),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
      .fetch_count(fetch_count)
   );

   always #5 CLK = ~CLK;

   // Memory image: the word at byte address a is its word index a/4.
   function automatic logic [31:0] memWord(input logic [11:0] a);
      return {22'h0, a[11:2]};
   endfunction

   assign I_MEM_DI = memWord(I_MEM_ADDR);

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic rv, input logic [11:0] rpc, input logic halt, input logic ready);
      redirect_valid = rv;
      redirect_pc    = rpc;
      halt_req       = halt;
      inst_ready     = ready;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic waitNeg();
      @(negedge CLK);
      #1;
   endtask

   task automatic resetPulse();
      RSTn = 1'b0;
      tick();
      tick();
      RSTn = 1'b1;
   endtask

   // Reference model: the FIFO is a plain queue of {pc, word}; advanced once per rising edge.
   logic [43:0] mq[$];
   logic [11:0] mpc;
   logic [31:0] mcount;
   int          mstate;

   always @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         mq.delete();
         mpc    = RESET_PC & 12'hFFC;
         mcount = 0;
         mstate = M_IDLE;
      end else if (redirect_valid) begin
         mq.delete();
         mpc    = redirect_pc & 12'hFFC;
         mstate = M_RUN;
      end else begin
         bit doPop;
         bit doPush;
         doPop  = (mq.size() != 0) && inst_ready;
         doPush = (mstate == M_RUN) && !halt_req && ((mq.size() < DEPTH) || doPop);
         if (doPop) void'(mq.pop_front());
         if (doPush) begin
            mq.push_back({mpc, memWord(mpc)});
            mpc    = mpc + 12'd4;
            mcount = mcount + 1;
         end
         if (mstate == M_IDLE) mstate = M_RUN;
         else if (mstate == M_RUN && halt_req) mstate = M_HALTED;
      end
   end

   always @(negedge CLK) begin
      if (RSTn) begin
         logic        expValid;
         logic [31:0] expInst;
         logic [11:0] expPc;
         expValid = (mq.size() != 0) && !redirect_valid;
         expInst  = (mq.size() != 0) ? mq[0][31:0] : NOP;
         expPc    = (mq.size() != 0) ? mq[0][43:32] : 12'h000;
         checkOutput("model inst_valid", {31'h0, inst_valid}, {31'h0, expValid});
         checkOutput("model inst", inst, expInst);
         checkOutput("model inst_pc", {20'h0, inst_pc}, {20'h0, expPc});
         checkOutput("model I_MEM_ADDR", {20'h0, I_MEM_ADDR}, {20'h0, mpc & 12'hFFC});
         checkOutput("model I_MEM_CSN", {31'h0, I_MEM_CSN}, {31'h0, !(mstate == M_RUN && !halt_req)});
         checkOutput("model fetch_count", fetch_count, mcount);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Reset release and streaming with decode always ready.
      applyStimulus(1'b0, 12'h000, 1'b0, 1'b1);
      resetPulse();
      waitNeg();
      checkOutput("idle csn", {31'h0, I_MEM_CSN}, 32'd1);
      checkOutput("idle valid", {31'h0, inst_valid}, 32'd0);
      checkOutput("idle inst nop", inst, NOP);
      tick();
      waitNeg();
      checkOutput("run csn", {31'h0, I_MEM_CSN}, 32'd0);
      checkOutput("run addr", {20'h0, I_MEM_ADDR}, 32'h000);
      checkOutput("run valid still 0", {31'h0, inst_valid}, 32'd0);
      tick();
      waitNeg();
      checkOutput("first valid", {31'h0, inst_valid}, 32'd1);
      checkOutput("first pc", {20'h0, inst_pc}, 32'h000);
      checkOutput("first count", fetch_count, 32'd1);
      tick();
      waitNeg();
      checkOutput("second pc", {20'h0, inst_pc}, 32'h004);
      checkOutput("second inst", inst, 32'd1);
      checkOutput("second count", fetch_count, 32'd2);
      tick();
      waitNeg();
      checkOutput("third pc", {20'h0, inst_pc}, 32'h008);

      // Back-pressure fills the FIFO, then drains back-to-back with no bubble.
      applyStimulus(1'b0, 12'h000, 1'b0, 1'b0);
      resetPulse();
      for (int i = 0; i < 7; i++) tick();
      waitNeg();
      checkOutput("full count", fetch_count, 32'd4);
      checkOutput("full addr held", {20'h0, I_MEM_ADDR}, 32'h010);
      checkOutput("full head pc", {20'h0, inst_pc}, 32'h000);
      applyStimulus(1'b0, 12'h000, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         checkOutput("drain valid", {31'h0, inst_valid}, 32'd1);
         checkOutput("drain pc", {20'h0, inst_pc}, 32'(i * 4));
         tick();
         waitNeg();
      end

      // Redirect with three entries queued.
      applyStimulus(1'b0, 12'h000, 1'b0, 1'b0);
      resetPulse();
      for (int i = 0; i < 4; i++) tick();
      waitNeg();
      checkOutput("three queued", fetch_count, 32'd3);
      applyStimulus(1'b1, 12'h104, 1'b0, 1'b1);
      #1;
      checkOutput("redirect masks valid", {31'h0, inst_valid}, 32'd0);
      tick();
      applyStimulus(1'b0, 12'h000, 1'b0, 1'b1);
      waitNeg();
      checkOutput("post-redirect empty", {31'h0, inst_valid}, 32'd0);
      tick();
      waitNeg();
      checkOutput("redirect target pc", {20'h0, inst_pc}, 32'h104);
      checkOutput("redirect target inst", inst, 32'h41);

      // Address wrap at the top of the 4 KiB space, and unaligned redirect.
      applyStimulus(1'b1, 12'hFF8, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 12'h000, 1'b0, 1'b1);
      tick();
      waitNeg();
      checkOutput("pc FF8", {20'h0, inst_pc}, 32'hFF8);
      tick();
      waitNeg();
      checkOutput("pc FFC", {20'h0, inst_pc}, 32'hFFC);
      tick();
      waitNeg();
      checkOutput("pc wrap", {20'h0, inst_pc}, 32'h000);
      applyStimulus(1'b1, 12'h103, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 12'h000, 1'b0, 1'b1);
      waitNeg();
      checkOutput("aligned addr", {20'h0, I_MEM_ADDR}, 32'h100);
      tick();
      waitNeg();
      checkOutput("aligned pc", {20'h0, inst_pc}, 32'h100);

      // Halt with two entries queued, drain, then resume via redirect.
      applyStimulus(1'b1, 12'h200, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 12'h000, 1'b0, 1'b0);
      tick();
      tick();
      applyStimulus(1'b0, 12'h000, 1'b1, 1'b0);
      waitNeg();
      checkOutput("halt csn", {31'h0, I_MEM_CSN}, 32'd1);
      tick();
      applyStimulus(1'b0, 12'h000, 1'b0, 1'b1);
      waitNeg();
      checkOutput("halt drain 0", {20'h0, inst_pc}, 32'h200);
      checkOutput("halted csn", {31'h0, I_MEM_CSN}, 32'd1);
      tick();
      waitNeg();
      checkOutput("halt drain 1", {20'h0, inst_pc}, 32'h204);
      tick();
      waitNeg();
      checkOutput("halt empty valid", {31'h0, inst_valid}, 32'd0);
      checkOutput("halt empty nop", inst, NOP);
      tick();
      tick();
      waitNeg();
      checkOutput("halt stays", {31'h0, inst_valid}, 32'd0);
      applyStimulus(1'b1, 12'h040, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 12'h000, 1'b0, 1'b1);
      waitNeg();
      checkOutput("resume csn", {31'h0, I_MEM_CSN}, 32'd0);
      tick();
      waitNeg();
      checkOutput("resume pc", {20'h0, inst_pc}, 32'h040);
      checkOutput("resume inst", inst, 32'h10);

      // Asynchronous reset with the FIFO full.
      applyStimulus(1'b0, 12'h000, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      waitNeg();
      checkOutput("pre-reset valid", {31'h0, inst_valid}, 32'd1);
      RSTn = 1'b0;
      #1;
      checkOutput("async valid", {31'h0, inst_valid}, 32'd0);
      checkOutput("async inst", inst, NOP);
      checkOutput("async pc", {20'h0, inst_pc}, 32'h000);
      checkOutput("async csn", {31'h0, I_MEM_CSN}, 32'd1);
      checkOutput("async count", fetch_count, 32'd0);
      checkOutput("async addr", {20'h0, I_MEM_ADDR}, {20'h0, RESET_PC});
      tick();
      applyStimulus(1'b0, 12'h000, 1'b0, 1'b1);
      RSTn = 1'b1;
      tick();
      tick();
      waitNeg();
      checkOutput("restart pc", {20'h0, inst_pc}, 32'h000);
      checkOutput("restart count", fetch_count, 32'd1);
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Prefetch stage directly upstream of the pipeline's IF/ID register.
- Drives the instruction-memory address, captures returned words with their PC into a small FIFO, and presents them to IF/ID through a valid/ready handshake.
- Decouples fetch from decode stalls (load-use hold via IF_ID_WE) and flushes on branch/jump redirect from EX.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- RESET_PC, 12'h000, first fetch byte address after reset.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- I_MEM_CSN  out  1  instruction-memory chip select, active-low.
- I_MEM_ADDR  out  12  instruction-memory byte address.
- I_MEM_DI  in  32  instruction word, valid combinationally for the current I_MEM_ADDR.
- redirect_valid  in  1  EX-stage mispredict/jump: flush and refetch.
- redirect_pc  in  12  redirect target byte address.
- halt_req  in  1  stop issuing new fetches (program terminating).
- inst_ready  in  1  IF/ID can accept (IF_ID_WE).
- inst_valid  out  1  head entry valid.
- inst  out  32  head instruction word.
- inst_pc  out  12  head instruction byte address.
- fetch_count  out  32  number of words pushed into the FIFO since reset.

Behaviour:
- Reset (RSTn=0, async):
  - fetch_pc=RESET_PC; FIFO empty (rd_ptr=wr_ptr=0, count=0); fetch_count=0; state=IDLE.
  - inst_valid=0, inst=32'h00000013 (nop), inst_pc=0, I_MEM_CSN=1.
- States:
  - IDLE: one cycle after reset release, CSN=1, no push; next state RUN.
  - RUN: fetching. halt_req=1 (no redirect) -> HALTED.
  - HALTED: no push, CSN=1; FIFO still drains; redirect_valid=1 -> RUN with new fetch_pc; otherwise stay until reset.
- Fetch:
  - I_MEM_ADDR=fetch_pc & 12'hFFC (word aligned). I_MEM_CSN=0 only in RUN.
  - push = RUN & ~redirect_valid & ~halt_req & (count<DEPTH | pop).
  - On push: FIFO[wr_ptr]={fetch_pc, I_MEM_DI}; wr_ptr++; fetch_pc+=4, wrapping 12'hFFC -> 12'h000; fetch_count++ (wraps at 2^32).
  - No push -> fetch_pc holds.
- Drain:
  - inst_valid = (count!=0) & ~redirect_valid. redirect_valid masks valid combinationally.
  - inst/inst_pc = head entry when count!=0, else nop/0.
  - pop = inst_valid & inst_ready; rd_ptr++ on pop.
  - Pointers wrap modulo DEPTH. count = count + push - pop, never exceeding DEPTH or going below 0.
- Full:
  - count==DEPTH & ~pop: no push; I_MEM_ADDR stays on fetch_pc.
  - Full with simultaneous pop: push and pop both occur; count unchanged.
- Empty: inst_valid=0 and inst=nop. There is no same-cycle bypass, so a word pushed at edge N appears at the head after edge N.
- Redirect (priority over everything):
  - Next edge: rd_ptr=wr_ptr=0, count=0; fetch_pc=redirect_pc & 12'hFFC; state=RUN, even from HALTED.
  - No push and no pop that cycle; fetch_count unchanged.
  - The first fetch from the target is pushed on the following edge, giving redirect-to-inst_valid latency of 2 cycles.
- halt_req together with redirect_valid: the redirect wins and the state becomes RUN.
- Reset mid-operation: async clear regardless of FIFO contents or state.
- Steady state with inst_ready=1 and no redirect: one instruction per cycle. Latency from reset release to first inst_valid is 2 cycles (IDLE, then push).

Test Plan:
- Reset release, inst_ready=1, memory word[k]=k: inst_valid=1 at cycle 2; inst_pc sequence 0x000, 0x004, 0x008 with no gaps; fetch_count increments each cycle.
- inst_ready=0 for 6 cycles after start: exactly DEPTH=4 pushes, then I_MEM_ADDR held at 0x010; on inst_ready=1, inst_pc 0x000..0x00C pop back-to-back, then 0x010 follows with no bubble.
- Redirect to 0x104 while FIFO holds 3 entries: inst_valid=0 that cycle and the next; head becomes inst_pc=0x104 two cycles later; the stale entries never appear.
- Fetch up to 0xFFC: the next pushed inst_pc is 0x000 (wrap). redirect_pc=0x103 produces fetch at 0x100.
- halt_req asserted with 2 entries queued: no further I_MEM_CSN=0 or pushes; both entries drain, then inst_valid=0 and inst=0x00000013; a subsequent redirect to 0x040 resumes fetching from 0x040.
- RSTn pulsed low mid-stream with FIFO full: outputs clear immediately (before the next edge); fetch restarts at RESET_PC; fetch_count=0.
